// File: rtl/if_stage_ctrl.sv
// Fetch-side controller: owns the PC and the IF/ID register, applies hazard holds,
// bubbles and branch flushes, and keeps saturating stall/flush counters.
module if_stage_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        PCWrite_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] instr_i,
    output logic [31:0] instr_addr_o,
    output logic [31:0] ID_pc_o,
    output logic [31:0] ID_instr_o,
    output logic        ID_valid_o,
    output logic        running_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        running;
    logic        flush_ok;
    logic        pc_hold;

    logic [31:0] pc_p0;
    logic [31:0] id_pc_p1;
    logic [31:0] id_instr_p1;
    logic        vld_p1;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // Only reset leaves RUN; start is a one-shot launch from IDLE.
    always_comb begin
        state_nxt = state;
        if (state == IDLE && start_i) state_nxt = RUN;
    end

    always_comb begin
        running = (state == RUN);
    end

    assign flush_ok = flush_i & ~stall_i;
    assign pc_hold  = stall_i | ~PCWrite_i;

    // PC (p0) -> IF/ID (p1); a stall holds both and blocks a same-cycle flush.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc_p0       <= RESET_PC;
            id_pc_p1    <= 32'h0;
            id_instr_p1 <= NOP_INSTR;
            vld_p1      <= 1'b0;
            stall_cnt   <= 32'h0;
            flush_cnt   <= 32'h0;
        end else if (running) begin
            if (flush_ok) begin
                pc_p0       <= {branch_target_i[31:2], 2'b00};
                id_pc_p1    <= pc_p0;
                id_instr_p1 <= NOP_INSTR;
                vld_p1      <= 1'b0;
                flush_cnt   <= sat_inc(flush_cnt);
            end else if (stall_i) begin
                stall_cnt   <= sat_inc(stall_cnt);
            end else if (pc_hold) begin
                id_pc_p1    <= pc_p0;
                id_instr_p1 <= NOP_INSTR;
                vld_p1      <= 1'b0;
            end else begin
                pc_p0       <= pc_p0 + 32'd4;
                id_pc_p1    <= pc_p0;
                id_instr_p1 <= instr_i;
                vld_p1      <= 1'b1;
            end
        end
    end

    assign instr_addr_o = pc_p0;
    assign ID_pc_o      = id_pc_p1;
    assign ID_instr_o   = id_instr_p1;
    assign ID_valid_o   = vld_p1;
    assign running_o    = running;
    assign stall_cnt_o  = stall_cnt;
    assign flush_cnt_o  = flush_cnt;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed bench for if_stage_ctrl: memory returns its own address as the
// instruction word; a second instance starts at 0xFFFF_FFFC to show PC wrap.
module tb_if_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        PCWrite_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] branch_target_i;

    logic [31:0] instr_addr, id_pc, id_instr, stall_cnt, flush_cnt;
    logic        id_valid, running;
    logic [31:0] w_instr_addr, w_id_pc, w_id_instr, w_stall_cnt, w_flush_cnt;
    logic        w_id_valid, w_running;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    if_stage_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .PCWrite_i(PCWrite_i),
        .stall_i(stall_i), .flush_i(flush_i), .branch_target_i(branch_target_i),
        .instr_i(instr_addr), .instr_addr_o(instr_addr), .ID_pc_o(id_pc),
        .ID_instr_o(id_instr), .ID_valid_o(id_valid), .running_o(running),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    if_stage_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .PCWrite_i(PCWrite_i),
        .stall_i(stall_i), .flush_i(flush_i), .branch_target_i(branch_target_i),
        .instr_i(w_instr_addr), .instr_addr_o(w_instr_addr), .ID_pc_o(w_id_pc),
        .ID_instr_o(w_id_instr), .ID_valid_o(w_id_valid), .running_o(w_running),
        .stall_cnt_o(w_stall_cnt), .flush_cnt_o(w_flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                            input logic vld);
        check({tag, "_pc"}, id_pc, pc);
        check({tag, "_instr"}, id_instr, ins);
        check({tag, "_valid"}, {31'b0, id_valid}, {31'b0, vld});
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_addr"}, instr_addr, 32'h0);
        check_id(tag, 32'h0, 32'h13, 1'b0);
        check({tag, "_running"}, {31'b0, running}, 32'h0);
        check({tag, "_stall_cnt"}, stall_cnt, 32'h0);
        check({tag, "_flush_cnt"}, flush_cnt, 32'h0);
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; PCWrite_i = 1'b1; stall_i = 1'b0;
        flush_i = 1'b0; branch_target_i = 32'h0;
        tick(); tick();
        check_reset("rst");
        check("wrap_rst_addr", w_instr_addr, 32'hFFFF_FFFC);

        // Out of reset but idle: nothing moves.
        rst_i = 1'b1;
        tick();
        check("idle_running", {31'b0, running}, 32'h0);
        check("idle_addr", instr_addr, 32'h0);

        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("start_running", {31'b0, running}, 32'h1);
        check("start_addr", instr_addr, 32'h0);
        check("start_valid", {31'b0, id_valid}, 32'h0);

        tick();
        check_id("fetch0", 32'h0, 32'h0, 1'b1);
        check("fetch0_addr", instr_addr, 32'h4);
        check("wrap_addr", w_instr_addr, 32'h0);
        check("wrap_id_pc", w_id_pc, 32'hFFFF_FFFC);
        tick();
        check_id("fetch1", 32'h4, 32'h4, 1'b1);
        check("wrap_addr2", w_instr_addr, 32'h4);
        tick();
        check_id("fetch2", 32'h8, 32'h8, 1'b1);
        tick();
        check_id("fetch3", 32'hC, 32'hC, 1'b1);
        check("fetch3_addr", instr_addr, 32'h10);

        // Two-cycle load-use stall at PC=0x10.
        stall_i = 1'b1; PCWrite_i = 1'b0;
        tick();
        check("stall1_addr", instr_addr, 32'h10);
        check_id("stall1", 32'hC, 32'hC, 1'b1);
        check("stall1_cnt", stall_cnt, 32'h1);
        tick();
        check("stall2_addr", instr_addr, 32'h10);
        check_id("stall2", 32'hC, 32'hC, 1'b1);
        check("stall2_cnt", stall_cnt, 32'h2);
        stall_i = 1'b0; PCWrite_i = 1'b1;
        tick();
        check_id("resume", 32'h10, 32'h10, 1'b1);
        check("resume_addr", instr_addr, 32'h14);

        tick(); tick(); tick();
        check("pre_flush_addr", instr_addr, 32'h20);

        // Taken branch to a misaligned target; low bits are dropped.
        flush_i = 1'b1; branch_target_i = 32'h103;
        tick();
        flush_i = 1'b0;
        check("flush_addr", instr_addr, 32'h100);
        check_id("flush_bubble", 32'h20, 32'h13, 1'b0);
        check("flush_cnt1", flush_cnt, 32'h1);
        tick();
        check_id("flush_target", 32'h100, 32'h100, 1'b1);
        check("flush_next_addr", instr_addr, 32'h104);

        // Flush coincident with stall: stall wins, flush not counted.
        flush_i = 1'b1; stall_i = 1'b1; PCWrite_i = 1'b0; branch_target_i = 32'h200;
        tick();
        check("fs_addr", instr_addr, 32'h104);
        check_id("fs", 32'h100, 32'h100, 1'b1);
        check("fs_flush_cnt", flush_cnt, 32'h1);
        check("fs_stall_cnt", stall_cnt, 32'h3);
        flush_i = 1'b0; stall_i = 1'b0; PCWrite_i = 1'b1;
        tick();
        check_id("fs_resume", 32'h104, 32'h104, 1'b1);

        // Back-to-back flushes.
        flush_i = 1'b1; branch_target_i = 32'h300;
        tick();
        check("b2b1_addr", instr_addr, 32'h300);
        check("b2b1_cnt", flush_cnt, 32'h2);
        branch_target_i = 32'h400;
        tick();
        flush_i = 1'b0;
        check("b2b2_addr", instr_addr, 32'h400);
        check_id("b2b2", 32'h300, 32'h13, 1'b0);
        check("b2b2_cnt", flush_cnt, 32'h3);
        tick();
        check_id("b2b_target", 32'h400, 32'h400, 1'b1);
        check("b2b_next_addr", instr_addr, 32'h404);

        // PCWrite low alone: PC holds and a bubble enters ID.
        PCWrite_i = 1'b0;
        tick();
        PCWrite_i = 1'b1;
        check("pcw_addr", instr_addr, 32'h404);
        check_id("pcw_bubble", 32'h404, 32'h13, 1'b0);
        check("pcw_stall_cnt", stall_cnt, 32'h3);
        tick();
        check_id("pcw_resume", 32'h404, 32'h404, 1'b1);
        check("pcw_next_addr", instr_addr, 32'h408);

        // Mid-run reset, then start is needed again.
        rst_i = 1'b0;
        tick();
        check_reset("midrst");
        rst_i = 1'b1;
        tick();
        check("midrst_idle_running", {31'b0, running}, 32'h0);
        check("midrst_idle_addr", instr_addr, 32'h0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("restart_running", {31'b0, running}, 32'h1);
        tick();
        check_id("restart_fetch", 32'h0, 32'h0, 1'b1);
        check("restart_addr", instr_addr, 32'h4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/if_stage_ctrl.md
# if_stage_ctrl

Fetch-side pipeline controller for the five-stage RISC-V core without branch prediction. It owns the PC register and the IF/ID pipeline register, and it drives the instruction-memory address. It consumes the load-use hazard outputs (PCWrite, stall) and the ID-stage branch redirect, applying them as PC holds, IF/ID holds, bubbles and flushes. It also keeps saturating stall and flush counters for performance readout.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INSTR, 32'h0000_0013, instruction word inserted as a bubble (addi x0,x0,0).

Ports:
- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous and active-low.
- start_i  in  1  begin fetching; sampled only in IDLE.
- PCWrite_i  in  1  from hazard unit; 0 means hold PC.
- stall_i  in  1  from hazard unit; 1 means hold IF/ID.
- flush_i  in  1  branch taken, resolved in ID.
- branch_target_i  in  32  redirect address, valid when flush_i=1.
- instr_i  in  32  instruction-memory read data for instr_addr_o (combinational memory).
- instr_addr_o  out  32  current PC, registered.
- ID_pc_o  out  32  PC of the instruction held in IF/ID.
- ID_instr_o  out  32  instruction held in IF/ID.
- ID_valid_o  out  1  1 when IF/ID holds a real fetched instruction.
- running_o  out  1  1 in RUN state.
- stall_cnt_o  out  32  cycles with the IF/ID hold applied.
- flush_cnt_o  out  32  accepted flushes.

## Operation
- FSM with two states.
  - IDLE: PC and IF/ID are frozen and the counters do not count.
  - Moves to RUN on the edge where start_i=1.
  - RUN: start_i is ignored. Only reset returns the FSM to IDLE.
- Derived signals in RUN:
  - pc_hold = stall_i | ~PCWrite_i
  - flush_ok = flush_i & ~stall_i
- Per-edge update in RUN, first match wins:
  1. flush_ok:
     - PC <= {branch_target_i[31:2], 2'b00}.
     - IF/ID <= {pc=PC, instr=NOP_INSTR, valid=0}.
     - flush_cnt increments.
  2. stall_i=1:
     - PC holds.
     - IF/ID holds all fields.
     - stall_cnt increments.
     - A flush_i asserted in the same cycle is ignored and not counted. The stalled branch re-evaluates on the next cycle.
  3. pc_hold=1 and stall_i=0 (PCWrite_i=0 alone):
     - PC holds.
     - IF/ID <= bubble {pc=PC, instr=NOP_INSTR, valid=0}. This prevents duplicate issue.
  4. Otherwise:
     - PC <= PC+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
     - IF/ID <= {pc=PC, instr=instr_i, valid=1}.
- Counters:
  - Both are 32-bit and saturate at 0xFFFF_FFFF with no wrap.
  - Both are cleared only by reset.
- Reset, value of every output:
  - PC = RESET_PC, so instr_addr_o = RESET_PC.
  - ID_pc_o = 0, ID_instr_o = NOP_INSTR, ID_valid_o = 0.
  - running_o = 0, stall_cnt_o = 0, flush_cnt_o = 0.
  - FSM = IDLE.
- Reset asserted mid-run overrides every other input on that edge. Any in-flight IF/ID content is discarded.

## Timing
- All outputs are registered and there are no combinational input-to-output paths.
- instr_i is sampled in the same cycle instr_addr_o presents its address.
- Fetch latency: the instruction at PC appears on ID_* one edge after PC is presented.
- First fetch:
  - The start_i edge moves the FSM to RUN; PC is still RESET_PC.
  - The next edge loads IF/ID with RESET_PC/instr_i and advances PC to RESET_PC+4.
- Stall of N consecutive cycles:
  - ID_* is held for N cycles and PC is unchanged for N cycles.
  - stall_cnt increases by N.
  - Normal fetch resumes on the first edge with stall_i=0.
- Flush:
  - PC shows the target one edge after flush_i.
  - ID_valid_o=0 for exactly one cycle.
  - The target instruction reaches ID on the following edge.
- Back-to-back flushes are each applied and each counted.

## Test plan
- Reset, then start_i=1 for one cycle with memory word = address:
  - ID_pc_o/ID_instr_o step 0,4,8,… with ID_valid_o=1.
  - running_o=1.
- stall_i=1, PCWrite_i=0 for 2 cycles while PC=0x10:
  - PC stays 0x10 and ID holds 0x0C for 2 cycles.
  - stall_cnt_o=2.
  - The next ID entry is 0x10.
- flush_i=1, target=0x103 at PC=0x20:
  - Next PC=0x100.
  - One bubble: ID_instr_o=0x13, ID_valid_o=0.
  - Then ID_pc_o=0x100.
  - flush_cnt_o=1.
- flush_i=1 and stall_i=1 in the same cycle:
  - PC and ID are held.
  - flush_cnt_o unchanged and stall_cnt_o +1.
- PCWrite_i=0, stall_i=0 for one cycle: PC holds and one bubble (valid=0) enters ID.
- Two further cases:
  - RESET_PC=0xFFFF_FFFC run for 2 cycles: PC wraps to 0.
  - Reset asserted mid-run: all outputs return to reset values and start_i is required again.
